// File: rtl/wb_pkg.sv
// Shared types, sizes and the ROB age helper for the writeback arbiter.
// The entry struct is what each lane FIFO stores and what a drain port emits.
package wb_pkg;
   localparam int LANES      = 8;
   localparam int WR_PORTS   = 4;
   localparam int FIFO_DEPTH = 4;
   localparam int XLEN       = 64;
   localparam int PREG_W     = 7;
   localparam int ROB_W      = 8;

   localparam int LANE_W = $clog2(LANES);
   localparam int PORT_W = $clog2(WR_PORTS);
   localparam int SEL_W  = PORT_W + 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   typedef struct packed {
      logic [XLEN-1:0]   data;
      logic [PREG_W-1:0] dest;
      logic [ROB_W-1:0]  rob;
   } wb_entry_t;

   // Distance of a ROB index from the head; wraps naturally at 2^ROB_W.
   function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] idx,
                                                 input logic [ROB_W-1:0] head);
      return idx - head;
   endfunction
endpackage

// File: rtl/wb_lane_fifo.sv
// Per-lane result FIFO with a combinational head, occupancy count and flush.
// A push into a full FIFO is dropped and reported on overflow.
module wb_lane_fifo
   import wb_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  wb_entry_t        push_entry,
   output wb_entry_t        head,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             overflow
);
   wb_entry_t        mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full  = (count == CNT_W'(FIFO_DEPTH));
   assign empty = (count == '0);

   // Fullness is judged on the pre-edge count; a same-cycle pop does not make room.
   assign do_push  = push && !full && !flush;
   assign do_pop   = pop && !empty && !flush;
   assign overflow = push && full && !flush;
   assign head     = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: buffers up to LANES results per cycle, drains WR_PORTS per
// cycle round-robin, and turns the oldest mispredict into a registered redirect.
module wb_arbiter
   import wb_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             flush_i,
   input  logic [LANES-1:0]                 wb_valid_i,
   input  logic [LANES-1:0][XLEN-1:0]       wb_data_i,
   input  logic [LANES-1:0][PREG_W-1:0]     wb_dest_i,
   input  logic [LANES-1:0][ROB_W-1:0]      wb_rob_idx_i,
   input  logic [LANES-1:0]                 br_mispredict_i,
   input  logic [LANES-1:0][XLEN-1:0]       br_target_i,
   input  logic [ROB_W-1:0]                 rob_head_i,
   output logic [WR_PORTS-1:0]              rf_we_o,
   output logic [WR_PORTS-1:0][PREG_W-1:0]  rf_waddr_o,
   output logic [WR_PORTS-1:0][XLEN-1:0]    rf_wdata_o,
   output logic [WR_PORTS-1:0]              rob_done_valid_o,
   output logic [WR_PORTS-1:0][ROB_W-1:0]   rob_done_idx_o,
   output logic [LANES-1:0]                 lane_almost_full_o,
   output logic                             overflow_err_o,
   output logic                             redirect_valid_o,
   output logic [XLEN-1:0]                  redirect_pc_o,
   output logic [ROB_W-1:0]                 redirect_rob_idx_o
);
   wb_entry_t           head       [LANES];
   logic [CNT_W-1:0]    count      [LANES];
   logic [LANES-1:0]    empty;
   logic [LANES-1:0]    lane_ovf;
   logic [LANES-1:0]    grant;
   logic [LANE_W-1:0]   rr_ptr;
   logic [LANE_W-1:0]   rr_next;
   logic [LANE_W-1:0]   scan_lane;
   logic [SEL_W-1:0]    nsel;
   logic [LANE_W-1:0]   port_lane  [WR_PORTS];
   logic [WR_PORTS-1:0] port_valid;
   logic [WR_PORTS-1:0] port_go;
   wb_entry_t           port_entry [WR_PORTS];
   logic                misp_any;
   logic [LANE_W-1:0]   misp_lane;
   logic [ROB_W-1:0]    best_age;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      wb_entry_t in_entry;
      assign in_entry = '{data: wb_data_i[gi], dest: wb_dest_i[gi], rob: wb_rob_idx_i[gi]};

      wb_lane_fifo u_fifo (
         .clk        (clk),
         .rst_n      (rst_n),
         .flush      (flush_i),
         .push       (wb_valid_i[gi]),
         .pop        (grant[gi]),
         .push_entry (in_entry),
         .head       (head[gi]),
         .count      (count[gi]),
         .empty      (empty[gi]),
         .overflow   (lane_ovf[gi])
      );

      assign lane_almost_full_o[gi] = (count[gi] >= CNT_W'(FIFO_DEPTH - 2));
   end

   // Round-robin multi-grant: the k-th non-empty lane in scan order goes to port k.
   always_comb begin
      grant      = '0;
      port_valid = '0;
      rr_next    = rr_ptr;
      scan_lane  = '0;
      nsel       = '0;
      for (int k = 0; k < WR_PORTS; k++) port_lane[k] = '0;
      for (int i = 0; i < LANES; i++) begin
         scan_lane = rr_ptr + LANE_W'(i);
         if (!empty[scan_lane] && nsel < SEL_W'(WR_PORTS)) begin
            grant[scan_lane]             = 1'b1;
            port_valid[nsel[PORT_W-1:0]] = 1'b1;
            port_lane[nsel[PORT_W-1:0]]  = scan_lane;
            rr_next                      = scan_lane + LANE_W'(1);
            nsel                         = nsel + SEL_W'(1);
         end
      end
   end

   for (genvar gi = 0; gi < WR_PORTS; gi++) begin : g_port
      assign port_entry[gi] = head[port_lane[gi]];
      assign port_go[gi]    = port_valid[gi] && !flush_i;
   end

   // Oldest mispredict; strict less-than keeps the lower lane on an age tie.
   always_comb begin
      misp_any  = 1'b0;
      misp_lane = '0;
      best_age  = '1;
      for (int i = 0; i < LANES; i++) begin
         if (wb_valid_i[i] && br_mispredict_i[i] &&
             (!misp_any || rob_age(wb_rob_idx_i[i], rob_head_i) < best_age)) begin
            misp_any  = 1'b1;
            misp_lane = LANE_W'(i);
            best_age  = rob_age(wb_rob_idx_i[i], rob_head_i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr             <= '0;
         rf_we_o            <= '0;
         rf_waddr_o         <= '0;
         rf_wdata_o         <= '0;
         rob_done_valid_o   <= '0;
         rob_done_idx_o     <= '0;
         overflow_err_o     <= 1'b0;
         redirect_valid_o   <= 1'b0;
         redirect_pc_o      <= '0;
         redirect_rob_idx_o <= '0;
      end else begin
         rr_ptr <= flush_i ? '0 : rr_next;
         if (|lane_ovf) overflow_err_o <= 1'b1;
         for (int k = 0; k < WR_PORTS; k++) begin
            rob_done_valid_o[k] <= port_go[k];
            rf_we_o[k]          <= port_go[k] && (port_entry[k].dest != '0);
            rf_waddr_o[k]       <= port_go[k] ? port_entry[k].dest : '0;
            rf_wdata_o[k]       <= port_go[k] ? port_entry[k].data : '0;
            rob_done_idx_o[k]   <= port_go[k] ? port_entry[k].rob  : '0;
         end
         redirect_valid_o <= misp_any && !flush_i;
         if (misp_any && !flush_i) begin
            redirect_pc_o      <= br_target_i[misp_lane];
            redirect_rob_idx_o <= wb_rob_idx_i[misp_lane];
         end
      end
   end
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic checked against
// a queue-based reference model of the lane buffering, drain order and redirect.
module tb_wb_arbiter;
   import wb_pkg::*;

   logic                            clk = 1'b0;
   logic                            rst_n = 1'b0;
   logic                            flush_i = 1'b0;
   logic [LANES-1:0]                wb_valid_i = '0;
   logic [LANES-1:0][XLEN-1:0]      wb_data_i = '0;
   logic [LANES-1:0][PREG_W-1:0]    wb_dest_i = '0;
   logic [LANES-1:0][ROB_W-1:0]     wb_rob_idx_i = '0;
   logic [LANES-1:0]                br_mispredict_i = '0;
   logic [LANES-1:0][XLEN-1:0]      br_target_i = '0;
   logic [ROB_W-1:0]                rob_head_i = '0;
   logic [WR_PORTS-1:0]             rf_we_o;
   logic [WR_PORTS-1:0][PREG_W-1:0] rf_waddr_o;
   logic [WR_PORTS-1:0][XLEN-1:0]   rf_wdata_o;
   logic [WR_PORTS-1:0]             rob_done_valid_o;
   logic [WR_PORTS-1:0][ROB_W-1:0]  rob_done_idx_o;
   logic [LANES-1:0]                lane_almost_full_o;
   logic                            overflow_err_o;
   logic                            redirect_valid_o;
   logic [XLEN-1:0]                 redirect_pc_o;
   logic [ROB_W-1:0]                redirect_rob_idx_o;

   always #5 clk = ~clk;

   wb_arbiter dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .flush_i            (flush_i),
      .wb_valid_i         (wb_valid_i),
      .wb_data_i          (wb_data_i),
      .wb_dest_i          (wb_dest_i),
      .wb_rob_idx_i       (wb_rob_idx_i),
      .br_mispredict_i    (br_mispredict_i),
      .br_target_i        (br_target_i),
      .rob_head_i         (rob_head_i),
      .rf_we_o            (rf_we_o),
      .rf_waddr_o         (rf_waddr_o),
      .rf_wdata_o         (rf_wdata_o),
      .rob_done_valid_o   (rob_done_valid_o),
      .rob_done_idx_o     (rob_done_idx_o),
      .lane_almost_full_o (lane_almost_full_o),
      .overflow_err_o     (overflow_err_o),
      .redirect_valid_o   (redirect_valid_o),
      .redirect_pc_o      (redirect_pc_o),
      .redirect_rob_idx_o (redirect_rob_idx_o)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model state: one queue per lane, a scan start lane and sticky flags.
   wb_entry_t           mq [LANES][$];
   int                  m_rr;
   bit                  m_ovf;
   logic [WR_PORTS-1:0] e_valid, e_we;
   logic [PREG_W-1:0]   e_waddr [WR_PORTS];
   logic [XLEN-1:0]     e_wdata [WR_PORTS];
   logic [ROB_W-1:0]    e_idx   [WR_PORTS];
   bit                  e_rv;
   logic [XLEN-1:0]     e_pc;
   logic [ROB_W-1:0]    e_rrob;
   logic [LANES-1:0]    e_af;

   task automatic model_reset();
      for (int l = 0; l < LANES; l++) mq[l].delete();
      m_rr = 0; m_ovf = 0; e_valid = '0; e_we = '0; e_rv = 0;
      e_pc = '0; e_rrob = '0; e_af = '0;
   endtask

   // Advances the model by one clock using the inputs currently driven.
   task automatic model_step();
      int ng, last, best;
      logic [ROB_W-1:0] age, best_age;
      bit g [LANES];
      wb_entry_t ent;
      e_valid = '0; e_we = '0; e_rv = 0;
      for (int k = 0; k < WR_PORTS; k++) begin
         e_waddr[k] = '0; e_wdata[k] = '0; e_idx[k] = '0;
      end
      if (flush_i) begin
         for (int l = 0; l < LANES; l++) mq[l].delete();
         m_rr = 0;
      end else begin
         ng = 0; last = -1; best = -1; best_age = '0;
         for (int l = 0; l < LANES; l++) g[l] = 0;
         for (int i = 0; i < LANES; i++) begin
            int l;
            l = (m_rr + i) % LANES;
            if (mq[l].size() > 0 && ng < WR_PORTS) begin
               e_valid[ng] = 1'b1;
               e_we[ng]    = (mq[l][0].dest != 0);
               e_waddr[ng] = mq[l][0].dest;
               e_wdata[ng] = mq[l][0].data;
               e_idx[ng]   = mq[l][0].rob;
               g[l] = 1; ng++; last = l;
            end
         end
         if (ng > 0) m_rr = (last + 1) % LANES;
         for (int l = 0; l < LANES; l++) begin
            if (wb_valid_i[l] && br_mispredict_i[l]) begin
               age = wb_rob_idx_i[l] - rob_head_i;
               if (best < 0 || age < best_age) begin best = l; best_age = age; end
            end
         end
         if (best >= 0) begin
            e_rv = 1; e_pc = br_target_i[best]; e_rrob = wb_rob_idx_i[best];
         end
         for (int l = 0; l < LANES; l++) begin
            bit was_full;
            was_full = (mq[l].size() == FIFO_DEPTH);
            if (g[l]) void'(mq[l].pop_front());
            if (wb_valid_i[l]) begin
               if (was_full) m_ovf = 1;
               else begin
                  ent.data = wb_data_i[l]; ent.dest = wb_dest_i[l]; ent.rob = wb_rob_idx_i[l];
                  mq[l].push_back(ent);
               end
            end
         end
      end
      for (int l = 0; l < LANES; l++) e_af[l] = (mq[l].size() >= FIFO_DEPTH - 2);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic clear_inputs();
      flush_i = 0; wb_valid_i = '0; wb_data_i = '0; wb_dest_i = '0; wb_rob_idx_i = '0;
      br_mispredict_i = '0; br_target_i = '0; rob_head_i = '0;
   endtask

   task automatic apply_reset();
      clear_inputs();
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      model_reset();
      #3;
      checks++; if (rf_we_o !== '0) begin errors++; $display("FAIL reset_we got=%b exp=0", rf_we_o); end
      checks++; if (rob_done_valid_o !== '0) begin errors++; $display("FAIL reset_done got=%b exp=0", rob_done_valid_o); end
      checks++; if (lane_almost_full_o !== '0) begin errors++; $display("FAIL reset_af got=%b exp=0", lane_almost_full_o); end
      checks++; if (overflow_err_o !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow_err_o); end
      checks++; if (redirect_valid_o !== 1'b0 || redirect_pc_o !== '0 || redirect_rob_idx_o !== '0) begin
         errors++; $display("FAIL reset_redirect got v=%b pc=%h rob=%h exp all 0", redirect_valid_o, redirect_pc_o, redirect_rob_idx_o); end
      checks++; if (rf_waddr_o !== '0 || rf_wdata_o !== '0 || rob_done_idx_o !== '0) begin
         errors++; $display("FAIL reset_fields got waddr=%h idx=%h exp 0", rf_waddr_o, rob_done_idx_o); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      $display("test_reset done at cycle %0d", cyc);
   endtask

   task automatic test_single();
      apply_reset();
      wb_valid_i[0] = 1; wb_dest_i[0] = 7'd5; wb_data_i[0] = 64'h1234; wb_rob_idx_i[0] = 8'd3;
      tick();
      clear_inputs();
      checks++; if (rob_done_valid_o !== '0) begin errors++; $display("FAIL single_early got=%b exp=0", rob_done_valid_o); end
      tick();
      checks++; if (rf_we_o !== 4'b0001) begin errors++; $display("FAIL single_we got=%b exp=0001", rf_we_o); end
      checks++; if (rob_done_valid_o !== 4'b0001) begin errors++; $display("FAIL single_done got=%b exp=0001", rob_done_valid_o); end
      checks++; if (rf_waddr_o[0] !== 7'd5 || rf_wdata_o[0] !== 64'h1234 || rob_done_idx_o[0] !== 8'd3) begin
         errors++; $display("FAIL single_fields got addr=%0d data=%h idx=%0d exp 5 1234 3", rf_waddr_o[0], rf_wdata_o[0], rob_done_idx_o[0]); end
      tick();
      checks++; if (rob_done_valid_o !== '0) begin errors++; $display("FAIL single_once got=%b exp=0", rob_done_valid_o); end
      $display("test_single done at cycle %0d", cyc);
   endtask

   task automatic test_all_lanes();
      apply_reset();
      for (int l = 0; l < LANES; l++) begin
         wb_valid_i[l] = 1; wb_dest_i[l] = PREG_W'(l + 10); wb_data_i[l] = 64'(l * 100); wb_rob_idx_i[l] = ROB_W'(l + 40);
      end
      tick();
      clear_inputs();
      tick();
      for (int k = 0; k < WR_PORTS; k++) begin
         checks++; if (rob_done_valid_o[k] !== 1'b1 || rf_waddr_o[k] !== PREG_W'(k + 10) || rob_done_idx_o[k] !== ROB_W'(k + 40)) begin
            errors++; $display("FAIL all_first port=%0d got v=%b addr=%0d exp v=1 addr=%0d", k, rob_done_valid_o[k], rf_waddr_o[k], k + 10); end
      end
      tick();
      for (int k = 0; k < WR_PORTS; k++) begin
         checks++; if (rf_we_o[k] !== 1'b1 || rf_waddr_o[k] !== PREG_W'(k + 14) || rf_wdata_o[k] !== 64'((k + 4) * 100)) begin
            errors++; $display("FAIL all_second port=%0d got we=%b addr=%0d exp we=1 addr=%0d", k, rf_we_o[k], rf_waddr_o[k], k + 14); end
      end
      // Scan pointer wrapped back to lane 0: a fresh lane 1 result lands on port 0.
      wb_valid_i[1] = 1; wb_dest_i[1] = 7'd33; wb_rob_idx_i[1] = 8'd9;
      tick();
      clear_inputs();
      tick();
      checks++; if (rob_done_valid_o !== 4'b0001 || rf_waddr_o[0] !== 7'd33) begin
         errors++; $display("FAIL all_wrap got v=%b addr=%0d exp v=0001 addr=33", rob_done_valid_o, rf_waddr_o[0]); end
      $display("test_all_lanes done at cycle %0d", cyc);
   endtask

   task automatic test_mispredict();
      apply_reset();
      rob_head_i = 8'd250;
      wb_valid_i[3] = 1; br_mispredict_i[3] = 1; wb_rob_idx_i[3] = 8'd5;  br_target_i[3] = 64'h4000;
      wb_valid_i[7] = 1; br_mispredict_i[7] = 1; wb_rob_idx_i[7] = 8'd10; br_target_i[7] = 64'h8000;
      tick();
      clear_inputs();
      checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 64'h4000 || redirect_rob_idx_o !== 8'd5) begin
         errors++; $display("FAIL misp_oldest got v=%b pc=%h rob=%0d exp 1 4000 5", redirect_valid_o, redirect_pc_o, redirect_rob_idx_o); end
      tick();
      checks++; if (redirect_valid_o !== 1'b0 || redirect_pc_o !== 64'h4000) begin
         errors++; $display("FAIL misp_pulse got v=%b pc=%h exp 0 4000", redirect_valid_o, redirect_pc_o); end
      // Equal ages: the lower lane wins. Mispredict without valid is ignored.
      wb_valid_i[1] = 1; br_mispredict_i[1] = 1; wb_rob_idx_i[1] = 8'd20; br_target_i[1] = 64'hA100;
      wb_valid_i[5] = 1; br_mispredict_i[5] = 1; wb_rob_idx_i[5] = 8'd20; br_target_i[5] = 64'hA500;
      br_mispredict_i[0] = 1; wb_rob_idx_i[0] = 8'd1; br_target_i[0] = 64'hDEAD;
      tick();
      clear_inputs();
      checks++; if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 64'hA100 || redirect_rob_idx_o !== 8'd20) begin
         errors++; $display("FAIL misp_tie got v=%b pc=%h rob=%0d exp 1 a100 20", redirect_valid_o, redirect_pc_o, redirect_rob_idx_o); end
      $display("test_mispredict done at cycle %0d", cyc);
   endtask

   task automatic test_overflow();
      int af_cyc, ovf_cyc;
      apply_reset();
      af_cyc = -1; ovf_cyc = -1;
      for (int c = 0; c < 12; c++) begin
         for (int l = 0; l < LANES; l++) begin
            wb_valid_i[l] = 1; wb_dest_i[l] = PREG_W'($urandom_range(1, 127)); wb_data_i[l] = {$urandom, $urandom};
            wb_rob_idx_i[l] = ROB_W'($urandom);
         end
         tick();
         if (af_cyc < 0 && lane_almost_full_o != '0) af_cyc = c;
         if (ovf_cyc < 0 && overflow_err_o === 1'b1) ovf_cyc = c;
         checks++; if (overflow_err_o !== m_ovf || lane_almost_full_o !== e_af) begin
            errors++; $display("FAIL ovf_track c=%0d got ovf=%b af=%b exp ovf=%b af=%b", c, overflow_err_o, lane_almost_full_o, m_ovf, e_af); end
      end
      checks++; if (!(af_cyc >= 0 && ovf_cyc >= 0 && af_cyc < ovf_cyc)) begin
         errors++; $display("FAIL ovf_order got af_cyc=%0d ovf_cyc=%0d exp af earlier than ovf", af_cyc, ovf_cyc); end
      clear_inputs();
      flush_i = 1;
      tick();
      clear_inputs();
      repeat (3) tick();
      checks++; if (overflow_err_o !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow_err_o); end
      $display("test_overflow done at cycle %0d", cyc);
   endtask

   task automatic test_flush();
      apply_reset();
      for (int c = 0; c < 2; c++) begin
         for (int l = 0; l < LANES; l++) begin
            wb_valid_i[l] = 1; wb_dest_i[l] = PREG_W'(l + 1); wb_rob_idx_i[l] = ROB_W'(c * 8 + l);
         end
         tick();
      end
      flush_i = 1; br_mispredict_i[2] = 1; br_target_i[2] = 64'hBEEF;
      tick();
      clear_inputs();
      checks++; if (rf_we_o !== '0 || rob_done_valid_o !== '0 || redirect_valid_o !== 1'b0) begin
         errors++; $display("FAIL flush_quiet got we=%b done=%b rv=%b exp all 0", rf_we_o, rob_done_valid_o, redirect_valid_o); end
      checks++; if (lane_almost_full_o !== '0) begin errors++; $display("FAIL flush_af got=%b exp=0", lane_almost_full_o); end
      wb_valid_i[0] = 1; wb_dest_i[0] = 7'd9; wb_data_i[0] = 64'hCAFE; wb_rob_idx_i[0] = 8'd77;
      tick();
      clear_inputs();
      checks++; if (rob_done_valid_o !== '0) begin errors++; $display("FAIL flush_empty got=%b exp=0", rob_done_valid_o); end
      tick();
      checks++; if (rob_done_valid_o !== 4'b0001 || rf_waddr_o[0] !== 7'd9 || rob_done_idx_o[0] !== 8'd77) begin
         errors++; $display("FAIL flush_resume got v=%b addr=%0d idx=%0d exp 0001 9 77", rob_done_valid_o, rf_waddr_o[0], rob_done_idx_o[0]); end
      checks++; if (overflow_err_o !== 1'b0) begin errors++; $display("FAIL flush_ovf got=%b exp=0", overflow_err_o); end
      $display("test_flush done at cycle %0d", cyc);
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int l = 0; l < LANES; l++) begin wb_valid_i[l] = 1; wb_dest_i[l] = PREG_W'(l + 1); end
      tick();
      clear_inputs();
      tick();
      checks++; if (rf_we_o !== 4'b1111) begin errors++; $display("FAIL areset_pre got=%b exp=1111", rf_we_o); end
      #2;
      rst_n = 0;
      model_reset();
      #1;
      checks++; if (rf_we_o !== '0 || rob_done_valid_o !== '0) begin
         errors++; $display("FAIL areset_now got we=%b done=%b exp 0", rf_we_o, rob_done_valid_o); end
      @(posedge clk);
      #1;
      rst_n = 1;
      repeat (3) begin
         tick();
         checks++; if (rob_done_valid_o !== '0 || lane_almost_full_o !== '0) begin
            errors++; $display("FAIL areset_lost got done=%b af=%b exp 0", rob_done_valid_o, lane_almost_full_o); end
      end
      $display("test_async_reset done at cycle %0d", cyc);
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 400; c++) begin
         flush_i    = ($urandom_range(0, 39) == 0);
         rob_head_i = ROB_W'($urandom);
         for (int l = 0; l < LANES; l++) begin
            wb_valid_i[l]      = ($urandom_range(0, 99) < 50);
            wb_data_i[l]       = {$urandom, $urandom};
            wb_dest_i[l]       = ($urandom_range(0, 9) == 0) ? '0 : PREG_W'($urandom);
            wb_rob_idx_i[l]    = ROB_W'($urandom_range(0, 15));
            br_mispredict_i[l] = ($urandom_range(0, 7) == 0);
            br_target_i[l]     = {$urandom, $urandom};
         end
         tick();
         checks++; if (rob_done_valid_o !== e_valid || rf_we_o !== e_we) begin
            errors++; $display("FAIL rand_valid c=%0d got done=%b we=%b exp done=%b we=%b", c, rob_done_valid_o, rf_we_o, e_valid, e_we); end
         for (int k = 0; k < WR_PORTS; k++) begin
            if (e_valid[k]) begin
               checks++; if (rf_waddr_o[k] !== e_waddr[k] || rf_wdata_o[k] !== e_wdata[k] || rob_done_idx_o[k] !== e_idx[k]) begin
                  errors++; $display("FAIL rand_port c=%0d k=%0d got addr=%0d idx=%0d exp addr=%0d idx=%0d", c, k, rf_waddr_o[k], rob_done_idx_o[k], e_waddr[k], e_idx[k]); end
            end
         end
         checks++; if (redirect_valid_o !== e_rv || redirect_pc_o !== e_pc || redirect_rob_idx_o !== e_rrob) begin
            errors++; $display("FAIL rand_redirect c=%0d got v=%b pc=%h rob=%0d exp v=%b pc=%h rob=%0d", c, redirect_valid_o, redirect_pc_o, redirect_rob_idx_o, e_rv, e_pc, e_rrob); end
         checks++; if (lane_almost_full_o !== e_af || overflow_err_o !== m_ovf) begin
            errors++; $display("FAIL rand_status c=%0d got af=%b ovf=%b exp af=%b ovf=%b", c, lane_almost_full_o, overflow_err_o, e_af, m_ovf); end
      end
      clear_inputs();
      $display("test_random done at cycle %0d", cyc);
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_lanes();
      test_mispredict();
      test_overflow();
      test_flush();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
